// File: rtl/rmw_long_latency_pkg.sv
// Shared types for the RMW long-latency datapath: initiator-side ids/tags/words
// plus the table responder's state, index and pipeline-stage types.
package rmw_long_latency_pkg;

  localparam int TAG_W       = 4;
  localparam int IN_FLIGHT_N = 2 ** TAG_W;

  typedef logic [15:0]      id_t;
  typedef logic [31:0]      word_t;
  typedef logic [TAG_W-1:0] tag_t;

  // Table responder
  localparam int TBL_LAT   = 16;
  localparam int TBL_IDX_W = 8;

  typedef logic [TBL_IDX_W-1:0] tbl_idx_t;

  typedef enum logic {
    TBL_INIT,
    TBL_RUN
  } tbl_state_t;

  typedef struct packed {
    logic     vld;
    tag_t     tag;
    tbl_idx_t idx;
    word_t    dat;
  } tbl_stage_t;

endpackage

// File: rtl/rmw_tbl_pipe_stage.sv
// One lookup-pipeline register. An accepted writeback whose index matches the
// entry being loaded replaces its data, so the entry never carries a stale word.
module rmw_tbl_pipe_stage
  import rmw_long_latency_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  tbl_stage_t d,
  input  logic       fwd_en,
  input  tbl_idx_t   fwd_idx,
  input  word_t      fwd_dat,
  output tbl_stage_t q
);

  tbl_stage_t d_fwd;

  // Forward a same-index writeback into the entry entering this stage.
  always_comb begin
    // NOTE: every always_comb output gets a default first, so no path can infer a latch.
    d_fwd = d;
    if (fwd_en && d.vld && (d.idx == fwd_idx)) begin
      d_fwd.dat = fwd_dat;
    end
  end

  // Stage register; reset drops any in-flight lookup.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: clocked state uses non-blocking <= so all registers update together at the edge.
    if (!rst_n) begin
      q <= '0;
    end else begin
      q <= d_fwd;
    end
  end

endmodule

// File: rtl/rmw_tbl_responder.sv
// Table-side responder: answers tagged lookups exactly LAT cycles after accept,
// accepts writebacks, and forwards writebacks into in-flight lookups so the
// response reflects every write accepted up to the cycle before it is returned.
// IDX_W must not exceed TBL_IDX_W (the stage struct carries a TBL_IDX_W index).
module rmw_tbl_responder
  import rmw_long_latency_pkg::*;
#(
  parameter int LAT   = TBL_LAT,
  parameter int IDX_W = TBL_IDX_W
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   lk_vld,
  input  tag_t                   lk_tag,
  input  id_t                    lk_id,
  output logic                   lk_rdy,
  input  logic                   wr_vld,
  input  id_t                    wr_id,
  input  word_t                  wr_dat,
  output logic                   wr_rdy,
  output logic                   rsp_vld,
  output tag_t                   rsp_tag,
  output word_t                  rsp_dat,
  output logic                   lk_err,
  output logic [IN_FLIGHT_N-1:0] busy_tags
);

  localparam int TBL_N = 2 ** IDX_W;
  localparam logic [IN_FLIGHT_N-1:0] TAG_ONE = IN_FLIGHT_N'(1);

  tbl_state_t       state_q, state_d;
  logic [IDX_W-1:0] init_idx_q, init_idx_d;

  logic             lk_acc, lk_dup, wr_acc;
  tbl_idx_t         lk_idx, wr_idx;
  logic             tbl_we;
  logic [IDX_W-1:0] tbl_waddr;
  word_t            tbl_wdat;
  word_t            tbl_mem [TBL_N];
  tbl_stage_t       lk_stage;
  tbl_stage_t       stage_d [LAT];
  tbl_stage_t       stage_q [LAT];
  logic [IN_FLIGHT_N-1:0] busy_set, busy_clr;

  // Upper id bits do not take part in indexing.
  logic unused_id_bits;
  assign unused_id_bits = ^{lk_id[$bits(id_t)-1:IDX_W], wr_id[$bits(id_t)-1:IDX_W]};

  // FSM state and init-sweep index registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= TBL_INIT;
      init_idx_q <= '0;
    end else begin
      state_q    <= state_d;
      init_idx_q <= init_idx_d;
    end
  end

  // INIT zeroes one entry per cycle and moves to RUN after the last one; RUN is terminal.
  always_comb begin
    state_d    = state_q;
    init_idx_d = init_idx_q;
    unique case (state_q)
      TBL_INIT: begin
        init_idx_d = init_idx_q + 1'b1;
        if (&init_idx_q) state_d = TBL_RUN;
      end
      TBL_RUN: ;
      default: state_d = TBL_INIT;
    endcase
  end

  assign lk_rdy = (state_q == TBL_RUN);
  assign wr_rdy = lk_rdy;
  assign lk_acc = lk_vld & lk_rdy & ~busy_tags[lk_tag];
  assign lk_dup = lk_vld & lk_rdy &  busy_tags[lk_tag];
  assign wr_acc = wr_vld & wr_rdy;
  assign lk_idx = tbl_idx_t'(lk_id[IDX_W-1:0]);
  assign wr_idx = tbl_idx_t'(wr_id[IDX_W-1:0]);

  // Single table write port shared by the init sweep and accepted writebacks.
  always_comb begin
    tbl_we    = wr_acc;
    tbl_waddr = wr_id[IDX_W-1:0];
    tbl_wdat  = wr_dat;
    if (state_q == TBL_INIT) begin
      tbl_we    = 1'b1;
      tbl_waddr = init_idx_q;
      tbl_wdat  = '0;
    end
  end

  // Table storage, written in the cycle a write is accepted.
  always_ff @(posedge clk) begin
    // NOTE: the table has no reset; the INIT sweep clears it, keeping it mappable to RAM.
    if (tbl_we) tbl_mem[tbl_waddr] <= tbl_wdat;
  end

  // New lookup entering the pipe; stage 0 forwarding gives write-first on a same-cycle write.
  always_comb begin
    lk_stage     = '0;
    lk_stage.vld = lk_acc;
    lk_stage.tag = lk_tag;
    lk_stage.idx = lk_idx;
    lk_stage.dat = tbl_mem[lk_id[IDX_W-1:0]];
  end

  for (genvar k = 0; k < LAT; k++) begin : g_stage
    if (k == 0) begin : g_head
      assign stage_d[k] = lk_stage;
    end else begin : g_link
      assign stage_d[k] = stage_q[k-1];
    end

    rmw_tbl_pipe_stage u_stage (
      .clk     (clk),
      .rst_n   (rst_n),
      .d       (stage_d[k]),
      .fwd_en  (wr_acc),
      .fwd_idx (wr_idx),
      .fwd_dat (wr_dat),
      .q       (stage_q[k])
    );
  end

  assign rsp_vld = stage_q[LAT-1].vld;
  assign rsp_tag = rsp_vld ? stage_q[LAT-1].tag : '0;
  assign rsp_dat = rsp_vld ? stage_q[LAT-1].dat : '0;

  // Tag bitmap updates: set on accept, clear on response.
  always_comb begin
    busy_set = lk_acc  ? (TAG_ONE << lk_tag)  : '0;
    busy_clr = rsp_vld ? (TAG_ONE << rsp_tag) : '0;
  end

  // In-flight tag bitmap and duplicate-tag error pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_tags <= '0;
      lk_err    <= 1'b0;
    end else begin
      busy_tags <= (busy_tags & ~busy_clr) | busy_set;
      lk_err    <= lk_dup;
    end
  end

endmodule

// File: tb/tb_rmw_tbl_responder.sv
// Self-checking bench for rmw_tbl_responder: a scoreboard queue of issued
// lookups plus a reference table model; responses are checked as they appear.
module tb_rmw_tbl_responder;
  import rmw_long_latency_pkg::*;

  localparam int LAT   = 16;
  localparam int TBL_N = 256;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        lk_vld;
  tag_t        lk_tag;
  id_t         lk_id;
  logic        lk_rdy;
  logic        wr_vld;
  id_t         wr_id;
  word_t       wr_dat;
  logic        wr_rdy;
  logic        rsp_vld;
  tag_t        rsp_tag;
  word_t       rsp_dat;
  logic        lk_err;
  logic [15:0] busy_tags;

  rmw_tbl_responder #(.LAT(LAT), .IDX_W(8)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .lk_vld    (lk_vld),
    .lk_tag    (lk_tag),
    .lk_id     (lk_id),
    .lk_rdy    (lk_rdy),
    .wr_vld    (wr_vld),
    .wr_id     (wr_id),
    .wr_dat    (wr_dat),
    .wr_rdy    (wr_rdy),
    .rsp_vld   (rsp_vld),
    .rsp_tag   (rsp_tag),
    .rsp_dat   (rsp_dat),
    .lk_err    (lk_err),
    .busy_tags (busy_tags)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] tag;
    logic [7:0] idx;
    int         due;
  } exp_t;

  exp_t        sb[$];
  word_t       model_tbl [TBL_N];
  bit   [15:0] mbusy = '0;
  int          cyc = 0;
  int          rel_cyc = 1 << 30;
  int          err_due = -1;
  int          n_chk = 0;
  int          n_pass = 0;
  int          n_rsp = 0;
  word_t       last_dat;
  tag_t        last_tag;
  word_t       rsp_by_tag [16];

  always @(posedge clk) cyc++;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    else n_pass++;
  endtask

  function automatic bit mrun();
    return rst_n && (cyc >= rel_cyc + TBL_N);
  endfunction

  // One cycle of stimulus; entered and left #1 after a rising edge.
  task automatic step(input logic lv, input logic [3:0] tg, input logic [15:0] lid,
                      input logic wv, input logic [15:0] wid, input logic [31:0] wd);
    bit run;
    exp_t e;
    run    = mrun();
    lk_vld = lv;
    lk_tag = tg;
    lk_id  = lid;
    wr_vld = wv;
    wr_id  = wid;
    wr_dat = wd;
    if (lv && run && !mbusy[tg]) begin
      e.tag = tg;
      e.idx = lid[7:0];
      e.due = cyc + LAT;
      sb.push_back(e);
      mbusy[tg] = 1'b1;
    end else if (lv && run) begin
      err_due = cyc + 1;
    end
    @(posedge clk);
    if (wv && run) model_tbl[wid[7:0]] = wd;
    #1;
    lk_vld = 1'b0;
    wr_vld = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 4'd0, 16'd0, 1'b0, 16'd0, 32'd0);
  endtask

  task automatic lookup(input logic [3:0] tg, input logic [15:0] lid);
    step(1'b1, tg, lid, 1'b0, 16'd0, 32'd0);
  endtask

  task automatic write(input logic [15:0] wid, input logic [31:0] wd);
    step(1'b0, 4'd0, 16'd0, 1'b1, wid, wd);
  endtask

  // Counts the not-ready cycles after reset release, bounded.
  task automatic init_wait();
    int n;
    n = 0;
    while (!lk_rdy && n < 300) begin
      idle(1);
      n++;
    end
    check("init_cycles", n, TBL_N);
  endtask

  // Response monitor: sampled on the falling edge.
  always @(negedge clk) begin : mon
    exp_t e;
    if (rst_n) begin
      if (rsp_vld) begin
        if (sb.size() == 0) begin
          check("rsp_unexpected", rsp_vld, 1'b0);
        end else begin
          e = sb.pop_front();
          check("rsp_tag", rsp_tag, e.tag);
          check("rsp_dat", rsp_dat, model_tbl[e.idx]);
          check("rsp_cycle", cyc, e.due);
          mbusy[e.tag]       = 1'b0;
          last_dat           = rsp_dat;
          last_tag           = rsp_tag;
          rsp_by_tag[e.tag]  = rsp_dat;
          n_rsp++;
        end
      end else if (sb.size() > 0 && sb[0].due <= cyc) begin
        e = sb.pop_front();
        check("rsp_missing", rsp_vld, 1'b1);
        mbusy[e.tag] = 1'b0;
      end
      if (lk_err || cyc == err_due) check("lk_err", lk_err, cyc == err_due);
    end
  end

  initial begin
    int n0;
    foreach (model_tbl[i]) model_tbl[i] = '0;
    foreach (rsp_by_tag[i]) rsp_by_tag[i] = '0;
    rst_n  = 1'b0;
    lk_vld = 1'b0; lk_tag = '0; lk_id = '0;
    wr_vld = 1'b0; wr_id  = '0; wr_dat = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_lk_rdy", lk_rdy, 1'b0);
    check("rst_wr_rdy", wr_rdy, 1'b0);
    check("rst_rsp_vld", rsp_vld, 1'b0);
    check("rst_busy", busy_tags, 16'h0000);
    check("rst_lk_err", lk_err, 1'b0);
    rst_n   = 1'b1;
    rel_cyc = cyc;
    init_wait();

    // Freshly zeroed table.
    lookup(4'd0, 16'h0042);
    idle(LAT + 1);
    check("zero_dat", last_dat, 32'h0);

    // Write then read through an aliased id.
    write(16'h0005, 32'hDEADBEEF);
    lookup(4'd3, 16'h0105);
    idle(LAT + 1);
    check("alias_tag", last_tag, 4'd3);
    check("alias_dat", last_dat, 32'hDEADBEEF);

    // Last write that lands in time vs. first one that does not.
    lookup(4'd5, 16'h0007);
    idle(14);
    write(16'h0007, 32'h11);
    write(16'h0007, 32'h22);
    idle(2);
    check("late_fwd_dat", last_dat, 32'h11);
    lookup(4'd6, 16'h0007);
    idle(LAT + 1);
    check("after_late_dat", last_dat, 32'h22);

    // One write updates two in-flight lookups of the same entry.
    lookup(4'd1, 16'h0009);
    lookup(4'd2, 16'h0009);
    idle(3);
    write(16'h0009, 32'hAA);
    idle(LAT + 1);
    check("multi_fwd_t1", rsp_by_tag[1], 32'hAA);
    check("multi_fwd_t2", rsp_by_tag[2], 32'hAA);

    // Same-cycle write and lookup: write-first.
    step(1'b1, 4'd7, 16'h0030, 1'b1, 16'h0030, 32'h5A5A0001);
    idle(LAT + 1);
    check("wr_first_dat", last_dat, 32'h5A5A0001);

    // Duplicate tag rejected; tag free again at T+LAT+1.
    n0 = n_rsp;
    lookup(4'd4, 16'h0010);
    lookup(4'd4, 16'h0011);
    check("dup_busy", busy_tags, 16'h0010);
    idle(LAT - 1);
    check("dup_one_rsp", n_rsp - n0, 1);
    check("dup_freed", busy_tags, 16'h0000);
    lookup(4'd4, 16'h0011);
    check("reissue_busy", busy_tags, 16'h0010);
    idle(LAT + 1);
    check("reissue_rsp", n_rsp - n0, 2);

    // Back-to-back burst of all tags with random writes to overlapping entries.
    n0 = n_rsp;
    for (int i = 0; i < 16; i++)
      step(1'b1, 4'(i), 16'(i), 1'($urandom_range(0, 1)), 16'($urandom_range(0, 15)), $urandom);
    check("burst_busy", busy_tags, 16'hFFFF);
    idle(LAT + 1);
    check("burst_rsps", n_rsp - n0, 16);
    check("burst_drain", busy_tags, 16'h0000);

    // Reset with lookups in flight.
    for (int i = 0; i < 8; i++) lookup(4'(i), 16'(i + 32));
    rst_n   = 1'b0;
    sb.delete();
    mbusy   = '0;
    err_due = -1;
    rel_cyc = 1 << 30;
    #1;
    check("midrst_busy", busy_tags, 16'h0000);
    check("midrst_rsp", rsp_vld, 1'b0);
    check("midrst_rdy", lk_rdy, 1'b0);
    idle(2);
    foreach (model_tbl[i]) model_tbl[i] = '0;
    n0      = n_rsp;
    rst_n   = 1'b1;
    rel_cyc = cyc;
    init_wait();
    check("midrst_no_rsp", n_rsp - n0, 0);
    lookup(4'd9, 16'h0005);
    idle(LAT + 1);
    check("rezero_dat", last_dat, 32'h0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
